// File: rtl/fifo_buffer_pkg.sv
// Shared constants and helpers for the parametrised FIFO and its storage.
package fifo_buffer_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dual_port_ram_p.sv
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered output. The array itself is never reset; only the output
// register can be cleared so the FIFO's data_out has a defined reset value.
module dual_port_ram_p
  import fifo_buffer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16384,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_enable,
  input  logic             read_reset,
  input  logic [AW-1:0]    read_address,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  // Registered read port; the output register alone has a synchronous clear.
  always_ff @(posedge clock) begin
    if (read_reset) begin
      data_out <= '0;
    end else if (read_enable) begin
      data_out <= mem[read_address];
    end
  end

endmodule

// File: rtl/fifo_buffer.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and optional first-word-fall-through read mode.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16384,
  parameter  int FWFT     = FIFO_STD,
  parameter  int AF_LEVEL = DEPTH - 4,
  parameter  int AE_LEVEL = 4,
  localparam int CW       = clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW        = CW - 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          flush;
  logic          full_i;
  logic          empty_i;
  logic          do_push;
  logic          do_pop;
  logic          ram_read;

  // Request qualification against the pre-edge flags.
  always_comb begin
    flush   = reset | (enable & clear);
    full_i  = (count_q == DEPTH_CNT);
    do_push = enable & push & ~full_i;
    do_pop  = enable & pop & ~empty_i;
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      logic ov;

      // Prefetch: refill the output stage whenever it is vacant or being popped.
      // rd_ptr tracks RAM reads, so the RAM holds data exactly when pointers differ.
      always_comb begin
        empty_i  = ~ov;
        ram_read = enable & (wr_ptr != rd_ptr) & (~ov | do_pop);
      end

      // Valid bit of the one-entry prefetch stage.
      always_ff @(posedge clock) begin
        if (flush) begin
          ov <= 1'b0;
        end else if (ram_read) begin
          ov <= 1'b1;
        end else if (do_pop) begin
          ov <= 1'b0;
        end
      end
    end else begin : g_std
      // Pointer equality including the wrap bit is equivalent to count == 0.
      always_comb begin
        empty_i  = (wr_ptr == rd_ptr);
        ram_read = do_pop;
      end
    end
  endgenerate

  // Read/write pointers with wrap bit; they roll over modulo 2*DEPTH.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (ram_read) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  // Occupancy: words accepted and not yet popped.
  always_ff @(posedge clock) begin
    if (flush) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clock) begin
    if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enable & push & full_i) begin
        overflow <= 1'b1;
      end
      if (enable & pop & empty_i) begin
        underflow <= 1'b1;
      end
    end
  end

  // Status outputs derived from the registered count.
  always_comb begin
    full         = full_i;
    empty        = empty_i;
    count        = count_q;
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  dual_port_ram_p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock         (clock),
    .write_enable  (do_push & ~flush),
    .write_address (wr_ptr[AW-1:0]),
    .write_data    (data_in),
    .read_enable   (ram_read),
    .read_reset    (flush),
    .read_address  (rd_ptr[AW-1:0]),
    .data_out      (data_out)
  );

endmodule

// File: tb/tb_fifo_buffer.sv
// Testbench for fifo_buffer: one standard-mode and one FWFT-mode instance.
module tb_fifo_buffer;
  import fifo_buffer_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Standard-mode instance (DEPTH 8, AF 6, AE 2)
  logic       s_reset, s_enable, s_clear, s_push, s_pop;
  logic [7:0] s_data_in, s_data_out;
  logic       s_full, s_empty, s_almost_full, s_almost_empty, s_overflow, s_underflow;
  logic [3:0] s_count;

  // FWFT-mode instance (DEPTH 8, default thresholds)
  logic       f_reset, f_enable, f_clear, f_push, f_pop;
  logic [7:0] f_data_in, f_data_out;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  logic [7:0] s_q[$];
  logic [7:0] f_q[$];
  bit         s_pend = 1'b0;

  fifo_buffer #(
    .WIDTH(8), .DEPTH(8), .FWFT(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clock(clock), .reset(s_reset), .enable(s_enable), .clear(s_clear),
    .push(s_push), .data_in(s_data_in), .pop(s_pop), .data_out(s_data_out),
    .full(s_full), .empty(s_empty), .almost_full(s_almost_full),
    .almost_empty(s_almost_empty), .count(s_count),
    .overflow(s_overflow), .underflow(s_underflow)
  );

  fifo_buffer #(
    .WIDTH(8), .DEPTH(8), .FWFT(FIFO_FWFT)
  ) u_fwft (
    .clock(clock), .reset(f_reset), .enable(f_enable), .clear(f_clear),
    .push(f_push), .data_in(f_data_in), .pop(f_pop), .data_out(f_data_out),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic std_reset_vals(input string tag);
    chk({tag, "_count"}, s_count, 0);
    chk({tag, "_empty"}, s_empty, 1);
    chk({tag, "_full"}, s_full, 0);
    chk({tag, "_ae"}, s_almost_empty, 1);
    chk({tag, "_af"}, s_almost_full, 0);
    chk({tag, "_ovf"}, s_overflow, 0);
    chk({tag, "_udf"}, s_underflow, 0);
    chk({tag, "_dout"}, s_data_out, 0);
  endtask

  // Standard-mode monitor: an accepted pop presents its word one cycle later.
  always @(negedge clock) begin
    if (s_pend) begin
      if (s_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL std_data: got 0x%0h expected no word", s_data_out);
      end else begin
        chk("std_data", s_data_out, s_q.pop_front());
      end
    end
    s_pend = s_enable && !s_clear && !s_reset && s_pop && !s_empty;
  end

  // FWFT monitor: the head word is on data_out in the cycle it is popped.
  always @(negedge clock) begin
    if (f_enable && !f_clear && !f_reset && f_pop && !f_empty) begin
      if (f_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fwft_data: got 0x%0h expected no word", f_data_out);
      end else begin
        chk("fwft_data", f_data_out, f_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_reset = 1; s_enable = 1; s_clear = 0; s_push = 0; s_pop = 0; s_data_in = '0;
    f_reset = 1; f_enable = 1; f_clear = 0; f_push = 0; f_pop = 0; f_data_in = '0;
    tick(); tick();
    s_reset = 0; f_reset = 0;
    std_reset_vals("std_rst");

    // Fill 0x01..0x08, thresholds tracked per step
    for (int i = 1; i <= 8; i++) begin
      s_push = 1; s_data_in = 8'(i); s_q.push_back(8'(i));
      tick();
      chk("fill_count", s_count, i);
      chk("fill_ae", s_almost_empty, (i <= 2));
      chk("fill_af", s_almost_full, (i >= 6));
      chk("fill_full", s_full, (i == 8));
    end
    s_data_in = 8'hFF;
    tick();
    s_push = 0;
    chk("ovf_flag", s_overflow, 1);
    chk("ovf_count", s_count, 8);

    // Drain
    s_pop = 1;
    repeat (8) tick();
    s_pop = 0;
    tick();
    chk("drain_empty", s_empty, 1);
    chk("drain_count", s_count, 0);
    chk("drain_hold", s_data_out, 8'h08);

    // Pop while empty
    s_pop = 1; tick(); s_pop = 0;
    chk("udf_flag", s_underflow, 1);
    chk("udf_count", s_count, 0);
    chk("udf_hold", s_data_out, 8'h08);

    // Clear at count 5
    for (int i = 0; i < 5; i++) begin
      s_push = 1; s_data_in = 8'(8'h21 + i); tick();
    end
    s_push = 0;
    chk("pre_clear_count", s_count, 5);
    s_clear = 1; tick(); s_clear = 0;
    std_reset_vals("std_clr");

    // Enable low freezes everything
    for (int i = 0; i < 5; i++) begin
      s_push = 1; s_data_in = 8'(8'h51 + i); s_q.push_back(8'(8'h51 + i)); tick();
    end
    s_push = 0;
    s_enable = 0; s_push = 1; s_pop = 1; s_clear = 1; s_data_in = 8'hEE;
    repeat (5) tick();
    s_enable = 1; s_push = 0; s_pop = 0; s_clear = 0;
    chk("frz_count", s_count, 5);
    chk("frz_empty", s_empty, 0);
    chk("frz_ovf", s_overflow, 0);
    chk("frz_udf", s_underflow, 0);
    chk("frz_dout", s_data_out, 0);

    // Push+pop while full: pop wins, push dropped
    for (int i = 0; i < 3; i++) begin
      s_push = 1; s_data_in = 8'(8'h56 + i); s_q.push_back(8'(8'h56 + i)); tick();
    end
    chk("full_again", s_full, 1);
    s_push = 1; s_pop = 1; s_data_in = 8'h99;
    tick();
    s_push = 0; s_pop = 0;
    chk("fullpp_count", s_count, 7);
    chk("fullpp_ovf", s_overflow, 1);
    chk("fullpp_dout", s_data_out, 8'h51);

    // Reset mid-stream
    s_reset = 1; tick(); s_reset = 0;
    s_q.delete();
    std_reset_vals("std_rst2");

    // Wrap-around: 3 rounds of push-5/pop-5
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        s_push = 1; s_data_in = 8'(8'h60 + r * 16 + i); s_q.push_back(8'(8'h60 + r * 16 + i));
        tick();
        chk("wrap_nofull", s_full, 0);
      end
      s_push = 0;
      chk("wrap_count5", s_count, 5);
      s_pop = 1; repeat (5) tick(); s_pop = 0;
      tick();
      chk("wrap_count0", s_count, 0);
    end

    // Simultaneous push/pop at count 3
    for (int i = 0; i < 3; i++) begin
      s_push = 1; s_data_in = 8'(8'h30 + i); s_q.push_back(8'(8'h30 + i)); tick();
    end
    for (int i = 0; i < 10; i++) begin
      s_push = 1; s_pop = 1; s_data_in = 8'(8'h40 + i); s_q.push_back(8'(8'h40 + i));
      tick();
      chk("simul_count", s_count, 3);
    end
    s_push = 0;
    repeat (3) tick();
    s_pop = 0;
    tick();
    chk("simul_end_count", s_count, 0);
    chk("simul_end_empty", s_empty, 1);

    // FWFT: reset state
    chk("fwft_rst_empty", f_empty, 1);
    chk("fwft_rst_count", f_count, 0);
    chk("fwft_rst_dout", f_data_out, 0);
    chk("fwft_rst_udf", f_underflow, 0);

    // Single push: count leads empty by one cycle
    f_push = 1; f_data_in = 8'hA5; f_q.push_back(8'hA5);
    tick();
    f_push = 0;
    chk("fwft_lag_count", f_count, 1);
    chk("fwft_lag_empty", f_empty, 1);
    tick();
    chk("fwft_fall_empty", f_empty, 0);
    chk("fwft_fall_dout", f_data_out, 8'hA5);
    f_pop = 1; tick(); f_pop = 0;
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_count", f_count, 0);
    f_pop = 1; tick(); f_pop = 0;
    chk("fwft_udf", f_underflow, 1);

    // Streaming pops, one word per cycle
    for (int i = 0; i < 6; i++) begin
      f_push = 1; f_data_in = 8'(8'h11 + i); f_q.push_back(8'(8'h11 + i)); tick();
    end
    f_push = 0;
    tick();
    chk("fwft_stream_count", f_count, 6);
    chk("fwft_stream_head", f_data_out, 8'h11);
    f_pop = 1;
    for (int i = 0; i < 6; i++) begin
      chk("fwft_stream_avail", f_empty, 0);
      tick();
    end
    f_pop = 0;
    chk("fwft_stream_done_empty", f_empty, 1);
    chk("fwft_stream_done_count", f_count, 0);

    tick();
    chk("std_queue_drained", s_q.size(), 0);
    chk("fwft_queue_drained", f_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO for byte- or word-stream buffering between the link receivers/transmitters and the framing logic. It generalises the fixed 8-bit, 16K-entry FIFO with configurable width and depth and an optional first-word-fall-through (FWFT) read mode. It also adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Storage is a single-clock simple dual-port RAM with registered read.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16384, number of entries; power of two, >= 4
- FWFT, 0, 0 = standard read (data one cycle after pop); 1 = first-word-fall-through
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

The port list below uses the derived constant CW = clog2(DEPTH)+1.

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; reset reset, synchronous, active-high; clock clock
- enable  in  1  global qualifier; low freezes all state and ignores push/pop/clear
- clear  in  1  synchronous flush, qualified by enable
- push  in  1  write request
- data_in  in  WIDTH  write data
- pop  in  1  read request
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  no word available at read side
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  words accepted and not yet popped
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Pointers rd_ptr and wr_ptr are CW bits wide and include an extra wrap bit. They increment modulo 2*DEPTH. The RAM address is the low CW-1 bits.
- Accepted push: do_push = enable & push & ~full. Accepted pop: do_pop = enable & pop & ~empty.
- Both decisions use the pre-edge flags. When full, a push is rejected even if a pop occurs in the same cycle. When empty, a pop is rejected even if a push occurs in the same cycle.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- count increments on push-only, decrements on pop-only, and otherwise holds. full, almost_full and almost_empty are derived combinationally from the registered count.
- Standard mode (FWFT=0): empty = (count == 0). On do_pop, the RAM read at rd_ptr is registered into data_out. data_out holds its value until the next accepted pop.
- FWFT mode (FWFT=1): the output register and a valid bit (ov) act as a one-entry prefetch stage. The RAM read is issued whenever the RAM holds data and either ov=0 or do_pop is asserted.
  - empty = ~ov.
  - data_out always presents the head word while empty=0.
  - count includes the word held in the prefetch stage.
- overflow sets on enable & push & full. underflow sets on enable & pop & empty. Both are cleared only by reset or clear.
- clear (with enable) has the same effect as reset on all state.
- RAM contents are never reset.
- Reset/clear values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (1 if AF_LEVEL == 0), overflow 0, underflow 0, data_out 0, ov 0.
- Reset or clear mid-stream discards all stored words. A push presented in the same cycle as reset/clear is dropped.

## Timing
- Push at edge N: count and full update at N+1. Standard mode: empty deasserts at N+1.
- FWFT mode, push into an empty FIFO at edge N:
  - RAM read at N+1.
  - ov=1, data_out valid and empty=0 at N+2.
  - count reads 1 from N+1, while empty is still 1 for one cycle.
- Standard pop at edge N: data_out valid after N+1, i.e. one cycle of read latency.
- FWFT back-to-back pops sustain one word per cycle while the RAM is non-empty.
- Throughput: one push and one pop per cycle. Maximum occupancy is DEPTH.
- A push to the address being read in the same cycle is impossible: the FIFO is full exactly when the pointers match on the low bits and differ in the wrap bit.

## Structure
- The shared package/include holds:
  - the clog2 function;
  - the FIFO mode constants FIFO_STD=0 and FIFO_FWFT=1.
- Sub-module dual_port_ram_p (parameters WIDTH, DEPTH):
  - one write port: data, address, write-enable;
  - one read port: address, registered data_out;
  - infers block RAM; no reset on the array.
- The FWFT prefetch logic lives inside fifo_buffer under a generate-if on FWFT.

## Test plan
- Standard mode, WIDTH=8, DEPTH=8: push 0x01..0x08 → full=1 and count=8 after the 8th edge. A 9th push of 0xFF → overflow=1, count stays 8. Pop ×8 → data_out 0x01..0x08, one cycle after each pop, then empty=1.
- Wrap-around: 3 rounds of push-5/pop-5 with DEPTH=8 → data order preserved across the pointer wrap, count returns to 0, full never asserts.
- Simultaneous push/pop: at count=3, push=pop=1 for 10 cycles → count stays 3 and output order is correct. At full, push+pop → pop accepted, push dropped, overflow=1, count=7.
- FWFT, DEPTH=8:
  - single push of 0xA5 into empty → empty falls two edges later with data_out=0xA5;
  - pop with empty=1 → underflow=1;
  - continuous pop over 6 words → one word per cycle.
- Thresholds with AF_LEVEL=6, AE_LEVEL=2: fill from 0 → almost_empty drops at count=3, almost_full rises at count=6.
- Control: with enable=0, push/pop/clear for 5 cycles → no state change and no sticky flags. At count=5, clear → all reset values next cycle, overflow/underflow cleared. The same check is repeated with reset.
